// File: rtl/stream_pkg.sv
// Shared helpers for the stream_join / stream_fork family.
// Keeps the flattened-bus width arithmetic in one place so both blocks agree.
package stream_pkg;

  // Width of a flattened bus carrying num_beats beats of beat_wd bits each.
  function automatic int bus_wd(input int beat_wd, input int num_beats);
    return beat_wd * num_beats;
  endfunction

  // Width of the joined {b,a} word produced by stream_join.
  function automatic int joined_wd(input int beat_wd);
    return 2 * beat_wd;
  endfunction

endpackage

// File: rtl/stream_fork.sv
// Eager broadcast fork: one valid/ready input beat is offered to NUM_OUT consumers,
// each takes it once in any order, and the input retires when all have taken it.
module stream_fork
  import stream_pkg::*;
#(
  parameter int DATA_WD  = 8,
  parameter int NUM_OUT  = 2,
  parameter bit HAS_LAST = 1'b0
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [DATA_WD-1:0]                  i_data,
  input  logic                                i_valid,
  input  logic                                i_last,
  output logic                                i_ready,
  output logic [bus_wd(DATA_WD, NUM_OUT)-1:0] o_data,
  output logic [NUM_OUT-1:0]                  o_valid,
  output logic [NUM_OUT-1:0]                  o_last,
  input  logic [NUM_OUT-1:0]                  o_ready
);

  logic [NUM_OUT-1:0] served;
  logic [NUM_OUT-1:0] served_nxt;
  logic [NUM_OUT-1:0] fire;

  // Data and sideband are pure fan-out: no storage, zero latency.
  assign o_data = {NUM_OUT{i_data}};
  assign o_last = HAS_LAST ? {NUM_OUT{i_last}} : '0;

  // An output already served for this beat must not see it again.
  assign o_valid = {NUM_OUT{i_valid}} & ~served;
  assign fire    = o_valid & o_ready;

  // Retire once every output has either taken the beat earlier or takes it now.
  assign i_ready = i_valid & (&(served | fire));

  always_comb begin
    served_nxt = served | fire;
    if (i_ready) begin
      served_nxt = '0;
    end
  end

  // Served-flag register; reset acts as a flush so a held beat is re-offered to all.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      served <= '0;
    end else begin
      served <= served_nxt;
    end
  end

endmodule

// File: tb/tb_stream_fork.sv
// Self-checking bench for stream_fork: directed corner cases plus a randomized stream,
// compared against a beat-counting reference model.
module tb_stream_fork;

  localparam int DATA_WD = 8;
  localparam int NUM_OUT = 2;

  logic                        clk = 1'b0;
  logic                        rstn;
  logic [DATA_WD-1:0]          i_data;
  logic                        i_valid;
  logic                        i_last;
  logic                        i_ready;
  logic [DATA_WD*NUM_OUT-1:0]  o_data;
  logic [NUM_OUT-1:0]          o_valid;
  logic [NUM_OUT-1:0]          o_last;
  logic [NUM_OUT-1:0]          o_ready;

  always #5 clk = ~clk;

  stream_fork #(
    .DATA_WD (DATA_WD),
    .NUM_OUT (NUM_OUT),
    .HAS_LAST(1'b1)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_last (i_last),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_last (o_last),
    .o_ready(o_ready)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: beats retired so far, and beats each consumer has taken.
  // A consumer still owes the current beat iff took[k] == in_cnt.
  int in_cnt = 0;
  int took [NUM_OUT];
  int ipulses = 0;
  logic [DATA_WD-1:0] rx [NUM_OUT][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_OUT-1:0] model_valid();
    logic [NUM_OUT-1:0] v;
    for (int k = 0; k < NUM_OUT; k++) v[k] = i_valid && (took[k] == in_cnt);
    return v;
  endfunction

  function automatic logic model_ready(input logic [NUM_OUT-1:0] v);
    logic r;
    r = i_valid;
    for (int k = 0; k < NUM_OUT; k++) r = r && ((took[k] > in_cnt) || (v[k] && o_ready[k]));
    return r;
  endfunction

  task automatic flush_model();
    for (int k = 0; k < NUM_OUT; k++) took[k] = in_cnt;
  endtask

  task automatic drive(input logic v, input logic [DATA_WD-1:0] d, input logic l,
                       input logic [NUM_OUT-1:0] r);
    i_valid = v;
    i_data  = d;
    i_last  = l;
    o_ready = r;
  endtask

  task automatic check_model(input string tag);
    logic [NUM_OUT-1:0] ev;
    logic er;
    ev = model_valid();
    er = model_ready(ev);
    chk({tag, ".o_valid"}, 32'(o_valid), 32'(ev));
    chk({tag, ".i_ready"}, 32'(i_ready), 32'(er));
    chk({tag, ".o_last"}, 32'(o_last), 32'({NUM_OUT{i_last}}));
    for (int k = 0; k < NUM_OUT; k++)
      chk($sformatf("%s.o_data%0d", tag, k), 32'(o_data[k*DATA_WD +: DATA_WD]), 32'(i_data));
  endtask

  task automatic tick();
    logic [NUM_OUT-1:0] ev;
    logic [NUM_OUT-1:0] f;
    logic er;
    logic live;
    ev   = model_valid();
    f    = ev & o_ready;
    er   = model_ready(ev);
    live = rstn;
    @(posedge clk);
    if (live) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (f[k]) begin
          took[k]++;
          rx[k].push_back(i_data);
        end
      end
      if (er) begin
        in_cnt++;
        ipulses++;
      end
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < NUM_OUT; k++) took[k] = 0;

    // Reset with a valid beat pending: offered to both, nothing retires.
    rstn = 1'b0;
    drive(1'b1, 8'hA5, 1'b0, 2'b00);
    @(negedge clk);
    check_model("rst");
    chk("rst.o_valid_const", 32'(o_valid), 32'(2'b11));
    chk("rst.i_ready_const", 32'(i_ready), 32'(1'b0));
    @(posedge clk);
    #2 rstn = 1'b1;
    #1;

    // First cycle after release with all ready: retires immediately.
    drive(1'b1, 8'hA5, 1'b0, 2'b11);
    @(negedge clk);
    check_model("rel");
    chk("rel.i_ready_const", 32'(i_ready), 32'(1'b1));
    tick();

    // Broadcast of a single beat.
    drive(1'b1, 8'hA5, 1'b0, 2'b11);
    @(negedge clk);
    check_model("bcast");
    chk("bcast.o_data_const", 32'(o_data), 32'(16'hA5A5));
    chk("bcast.i_ready_const", 32'(i_ready), 32'(1'b1));
    tick();

    // Idle input: nothing offered, nothing retired.
    drive(1'b0, 8'h3C, 1'b0, 2'b11);
    @(negedge clk);
    check_model("idle");
    chk("idle.o_valid_const", 32'(o_valid), 32'(2'b00));
    tick();

    // Skewed acceptance: output 0 then output 1.
    drive(1'b1, 8'h5A, 1'b0, 2'b01);
    @(negedge clk);
    check_model("skew0");
    chk("skew0.i_ready_const", 32'(i_ready), 32'(1'b0));
    tick();
    drive(1'b1, 8'h5A, 1'b0, 2'b10);
    @(negedge clk);
    check_model("skew1");
    chk("skew1.o_valid_const", 32'(o_valid), 32'(2'b10));
    chk("skew1.i_ready_const", 32'(i_ready), 32'(1'b1));
    tick();
    drive(1'b1, 8'h5B, 1'b0, 2'b00);
    @(negedge clk);
    chk("skew2.o_valid_const", 32'(o_valid), 32'(2'b11));

    // Stall: no consumer ready for five cycles.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 8'hA5, 1'b0, 2'b00);
      @(negedge clk);
      check_model($sformatf("stall%0d", c));
      chk("stall.o_valid_const", 32'(o_valid), 32'(2'b11));
      tick();
    end
    drive(1'b1, 8'hA5, 1'b0, 2'b11);
    @(negedge clk);
    check_model("stall_drain");
    tick();

    // Randomized stream of beats 0..15 with ~50% ready per output.
    in_cnt  = 0;
    ipulses = 0;
    flush_model();
    for (int k = 0; k < NUM_OUT; k++) rx[k].delete();
    for (int c = 0; c < 400 && in_cnt < 16; c++) begin
      drive(1'b1, 8'(in_cnt), 1'b0, 2'($urandom_range(0, 3)));
      @(negedge clk);
      check_model("stream");
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    chk("stream.retired", 32'(in_cnt), 32'd16);
    chk("stream.ipulses", 32'(ipulses), 32'd16);
    for (int k = 0; k < NUM_OUT; k++) begin
      chk($sformatf("stream.count%0d", k), 32'(rx[k].size()), 32'd16);
      for (int b = 0; b < 16 && b < rx[k].size(); b++)
        chk($sformatf("stream.out%0d.beat%0d", k, b), 32'(rx[k][b]), 32'(b));
    end

    // Last forwarding, then a reset in the middle of a partly served beat.
    drive(1'b1, 8'hC3, 1'b1, 2'b01);
    @(negedge clk);
    check_model("last0");
    chk("last0.o_last_const", 32'(o_last), 32'(2'b11));
    tick();
    drive(1'b1, 8'hC3, 1'b1, 2'b00);
    #1;
    chk("mid.o_valid_partial", 32'(o_valid), 32'(2'b10));
    #1 rstn = 1'b0;
    flush_model();
    #1;
    chk("mid.o_valid_async", 32'(o_valid), 32'(2'b11));
    check_model("mid_rst");
    @(posedge clk);
    #2 rstn = 1'b1;
    #1;
    drive(1'b1, 8'hC3, 1'b1, 2'b11);
    @(negedge clk);
    check_model("reoffer");
    chk("reoffer.o_valid_const", 32'(o_valid), 32'(2'b11));
    chk("reoffer.i_ready_const", 32'(i_ready), 32'(1'b1));
    tick();
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    @(negedge clk);
    check_model("end");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
